// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, RD, DONE} dmem_state_t;

    localparam int DMEM_ADDR_W_DEF = 11;
    localparam int DMEM_WAIT_DEF   = 1;
    localparam int DMEM_WAIT_MAX   = 15;
endpackage

// File: rtl/dmem_bank.sv
// Word-wide synchronous-read RAM with per-byte write enables; one read, one write port.
module dmem_bank #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       q
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re) q <= mem[raddr];
    end
endmodule

// File: rtl/dmem_responder.sv
// Load/store target for the RV32I core: byte-enabled single-cycle stores,
// loads stalled through halt for WAIT cycles before the full word is returned.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W_DEF,
    parameter int WAIT   = DMEM_WAIT_DEF
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic [3:0]  BE,
    input  logic        write_e,
    input  logic        read_e,
    output logic [31:0] rdata,
    output logic        halt,
    output logic        err
);
    localparam int          CNT_INIT_I = (WAIT > 1) ? WAIT - 2 : 0;
    localparam logic [3:0]  CNT_INIT   = 4'(CNT_INIT_I);

    dmem_state_t       state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] widx, widx_q, raddr;
    logic              in_range, rng_q, rd_ok;
    logic [3:0]        we;
    logic              re;
    logic              err_set;
    logic [31:0]       mem_q;

    assign widx     = address[ADDR_W+1:2];
    assign in_range = (address >> (ADDR_W + 2)) == 32'd0;

    // The RAM read is issued on the edge that enters DONE, so the bank's read
    // register doubles as the output register and only changes on that edge.
    dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
        .clk   (clk),
        .we    (we),
        .waddr (widx),
        .wdata (wdata),
        .re    (re),
        .raddr (raddr),
        .q     (mem_q)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        halt      = 1'b0;
        we        = '0;
        re        = 1'b0;
        raddr     = widx_q;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (read_e) begin
                    halt    = 1'b1;
                    err_set = write_e | ~in_range;
                    if (WAIT == 1) begin
                        state_nxt = DONE;
                        re        = 1'b1;
                        raddr     = widx;
                    end else begin
                        state_nxt = RD;
                        cnt_nxt   = CNT_INIT;
                    end
                end else if (write_e) begin
                    if (in_range) we = BE;
                    else          err_set = 1'b1;
                end
            end
            RD: begin
                halt = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    re        = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (res) begin
            halt = 1'b0;
            we   = '0;
            re   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rd_ok <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && read_e) begin
                widx_q <= widx;
                rng_q  <= in_range;
            end
            if (re) rd_ok <= (state == IDLE) ? in_range : rng_q;
            if (err_set) err <= 1'b1;
        end
    end

    // Out-of-range loads return zero; rd_ok updates on the same edge as mem_q.
    assign rdata = mem_q & {32{rd_ok}};
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at WAIT=1, 3 and 4 share stimulus.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        res;
    logic [31:0] address, wdata;
    logic [3:0]  be;
    logic        write_e, read_e;
    logic [31:0] rdata1, rdata3, rdata4;
    logic        halt1, halt3, halt4, err1, err3, err4;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(11), .WAIT(1)) u1 (.clk(clk), .res(res), .address(address), .wdata(wdata),
        .BE(be), .write_e(write_e), .read_e(read_e), .rdata(rdata1), .halt(halt1), .err(err1));
    dmem_responder #(.ADDR_W(11), .WAIT(3)) u3 (.clk(clk), .res(res), .address(address), .wdata(wdata),
        .BE(be), .write_e(write_e), .read_e(read_e), .rdata(rdata3), .halt(halt3), .err(err3));
    dmem_responder #(.ADDR_W(11), .WAIT(4)) u4 (.clk(clk), .res(res), .address(address), .wdata(wdata),
        .BE(be), .write_e(write_e), .read_e(read_e), .rdata(rdata4), .halt(halt4), .err(err4));

    // Start a new cycle: drive inputs just after the falling edge, settle 1 time unit.
    task automatic next(input logic r, input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        res = r; write_e = we; read_e = re; address = a; wdata = d; be = b;
        #1;
    endtask

    task automatic do_reset();
        next(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        next(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        next(1'b0, 1'b1, 1'b0, a, d, b);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({rdata1, halt1, err1} !== 34'h0) begin failures++;
            $display("FAIL reset_u1: got rdata=%h halt=%b err=%b want all 0", rdata1, halt1, err1); end
        checks++; if ({rdata3, halt3, err3} !== 34'h0) begin failures++;
            $display("FAIL reset_u3: got rdata=%h halt=%b err=%b want all 0", rdata3, halt3, err3); end
        checks++; if ({rdata4, halt4, err4} !== 34'h0) begin failures++;
            $display("FAIL reset_u4: got rdata=%h halt=%b err=%b want all 0", rdata4, halt4, err4); end
    endtask

    task automatic test_basic();
        do_reset();
        store(32'h10, 32'hDEADBEEF, 4'hF);
        next(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
        checks++; if (halt1 !== 1'b1) begin failures++;
            $display("FAIL basic_halt_c0: got %b want 1", halt1); end
        next(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (halt1 !== 1'b0) begin failures++;
            $display("FAIL basic_halt_c1: got %b want 0", halt1); end
        checks++; if (rdata1 !== 32'hDEADBEEF) begin failures++;
            $display("FAIL basic_rdata: got %h want deadbeef", rdata1); end
    endtask

    task automatic test_byte_enable();
        do_reset();
        store(32'h20, 32'h11223344, 4'hF);
        store(32'h20, 32'h00AA0000, 4'b0100);
        next(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
        next(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (rdata1 !== 32'h11AA3344) begin failures++;
            $display("FAIL be_rdata: got %h want 11aa3344", rdata1); end
        checks++; if (err1 !== 1'b0) begin failures++;
            $display("FAIL be_err: got %b want 0", err1); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        store(32'h20, 32'h11AA3344, 4'hF);
        store(32'h24, 32'hCAFEF00D, 4'hF);
        // First load: address scrambled after cycle 0 to show it is latched.
        next(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
        checks++; if (halt3 !== 1'b1) begin failures++; $display("FAIL w3_halt_c0: got %b want 1", halt3); end
        next(1'b0, 1'b0, 1'b1, 32'hFFFFFFF0, 32'h0, 4'h0);
        checks++; if (halt3 !== 1'b1) begin failures++; $display("FAIL w3_halt_c1: got %b want 1", halt3); end
        checks++; if (rdata3 !== 32'h0) begin failures++; $display("FAIL w3_rdata_hold_c1: got %h want 0", rdata3); end
        next(1'b0, 1'b0, 1'b1, 32'hFFFFFFF0, 32'h0, 4'h0);
        checks++; if (halt3 !== 1'b1) begin failures++; $display("FAIL w3_halt_c2: got %b want 1", halt3); end
        next(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
        checks++; if (halt3 !== 1'b0) begin failures++; $display("FAIL w3_halt_c3: got %b want 0", halt3); end
        checks++; if (rdata3 !== 32'h11AA3344) begin failures++; $display("FAIL w3_rdata_c3: got %h want 11aa3344", rdata3); end
        // Second load starts immediately after DONE.
        next(1'b0, 1'b0, 1'b1, 32'h24, 32'h0, 4'h0);
        checks++; if (halt3 !== 1'b1) begin failures++; $display("FAIL w3_halt_c4: got %b want 1", halt3); end
        next(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        checks++; if (rdata3 !== 32'h11AA3344) begin failures++; $display("FAIL w3_rdata_hold_c5: got %h want 11aa3344", rdata3); end
        next(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        checks++; if (halt3 !== 1'b1) begin failures++; $display("FAIL w3_halt_c6: got %b want 1", halt3); end
        next(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (halt3 !== 1'b0) begin failures++; $display("FAIL w3_halt_c7: got %b want 0", halt3); end
        checks++; if (rdata3 !== 32'hCAFEF00D) begin failures++; $display("FAIL w3_rdata_c7: got %h want cafef00d", rdata3); end
        next(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (halt3 !== 1'b0) begin failures++; $display("FAIL w3_halt_c8: got %b want 0", halt3); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        store(32'h0, 32'h13572468, 4'hF);
        store(32'h00002000, 32'hFFFFFFFF, 4'hF);
        next(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL oor_store_err: got %b want 1", err3); end
        // Word 0 aliases the dropped store's index; it must be untouched.
        for (int c = 0; c < 3; c++) next(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        next(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (rdata3 !== 32'h13572468) begin failures++; $display("FAIL oor_ram_kept: got %h want 13572468", rdata3); end
        for (int c = 0; c < 3; c++) begin
            next(1'b0, 1'b0, 1'b1, 32'h00002000, 32'h0, 4'h0);
            checks++; if (halt3 !== 1'b1) begin failures++; $display("FAIL oor_load_halt_c%0d: got %b want 1", c, halt3); end
        end
        next(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (halt3 !== 1'b0) begin failures++; $display("FAIL oor_load_halt_c3: got %b want 0", halt3); end
        checks++; if (rdata3 !== 32'h0) begin failures++; $display("FAIL oor_load_rdata: got %h want 0", rdata3); end
        checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL oor_err_sticky: got %b want 1", err3); end
        do_reset();
        checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL oor_err_cleared: got %b want 0", err3); end
    endtask

    task automatic test_rw_conflict();
        do_reset();
        store(32'h30, 32'h5, 4'hF);
        next(1'b0, 1'b1, 1'b1, 32'h30, 32'h9, 4'hF);
        checks++; if (halt1 !== 1'b1) begin failures++; $display("FAIL rw_halt: got %b want 1", halt1); end
        next(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (rdata1 !== 32'h5) begin failures++; $display("FAIL rw_rdata: got %h want 5", rdata1); end
        checks++; if (err1 !== 1'b1) begin failures++; $display("FAIL rw_err: got %b want 1", err1); end
        next(1'b0, 1'b0, 1'b1, 32'h30, 32'h0, 4'h0);
        next(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (rdata1 !== 32'h5) begin failures++; $display("FAIL rw_ram_kept: got %h want 5", rdata1); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        store(32'h40, 32'hA5A5A5A5, 4'hF);
        for (int c = 0; c < 4; c++) next(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
        next(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (rdata4 !== 32'hA5A5A5A5) begin failures++; $display("FAIL w4_rdata_first: got %h want a5a5a5a5", rdata4); end
        // Aborted load: reset lands in cycle 2.
        next(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
        next(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
        next(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
        checks++; if (halt4 !== 1'b0) begin failures++; $display("FAIL abort_halt_in_reset: got %b want 0", halt4); end
        next(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (halt4 !== 1'b0) begin failures++; $display("FAIL abort_halt_after: got %b want 0", halt4); end
        checks++; if (rdata4 !== 32'h0) begin failures++; $display("FAIL abort_rdata: got %h want 0", rdata4); end
        for (int c = 0; c < 4; c++) begin
            next(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
            checks++; if (halt4 !== 1'b1) begin failures++; $display("FAIL fresh_halt_c%0d: got %b want 1", c, halt4); end
        end
        next(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (halt4 !== 1'b0) begin failures++; $display("FAIL fresh_halt_c4: got %b want 0", halt4); end
        checks++; if (rdata4 !== 32'hA5A5A5A5) begin failures++; $display("FAIL fresh_rdata: got %h want a5a5a5a5", rdata4); end
    endtask

    initial begin
        res = 1'b1; write_e = 1'b0; read_e = 1'b0; address = '0; wdata = '0; be = '0;
        test_reset();
        test_basic();
        test_byte_enable();
        test_back_to_back();
        test_out_of_range();
        test_rw_conflict();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
